// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline hazard/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_MDU_WAIT   = 2'd1,
        S_TRAP_DRAIN = 2'd2
    } state_t;

    localparam int IF_ID      = 0;
    localparam int ID_EX      = 1;
    localparam int EX_MEM     = 2;
    localparam int MEM_WB     = 3;
    localparam int NUM_STAGES = 4;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and flush controller: drives stall/bubble controls for the
// four inter-stage registers and the PC. Owns no data.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TRAP_DRAIN = 3,
    parameter int CNT_W      = 2,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_use_i,
    input  logic                  br_taken_i,
    input  logic                  mdu_start_i,
    input  logic                  mdu_done_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    input  logic                  trap_i,
    output logic                  pc_stall_o,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] hold_o,
    output logic                  redirect_o,
    output logic                  trap_ack_o,
    output logic                  busy_o,
    output logic [PERF_W-1:0]     stall_cnt_o,
    output state_t                state_o
);

    // Counter holds the number of drain cycles still to come after the current
    // one, so the accept cycle plus the drain state total TRAP_DRAIN cycles.
    localparam logic [CNT_W-1:0] DRAIN_LOAD =
        (TRAP_DRAIN > 1) ? CNT_W'(TRAP_DRAIN - 2) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_wait;
    logic             flush;

    assign bus_wait = mem_req_i & ~mem_ack_i;
    assign busy_o   = (state_q != S_RUN);
    assign state_o  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_stall_o = 1'b0;
        stall_o    = '0;
        hold_o     = '0;
        redirect_o = 1'b0;
        trap_ack_o = 1'b0;
        flush      = 1'b0;

        case (state_q)
            S_RUN: begin
                // A pending trap blocks lower-priority events even while deferred.
                if (trap_i) begin
                    if (!bus_wait) begin
                        trap_ack_o = 1'b1;
                        redirect_o = 1'b1;
                        flush      = 1'b1;
                        if (TRAP_DRAIN > 1) begin
                            state_d = S_TRAP_DRAIN;
                            cnt_d   = DRAIN_LOAD;
                        end
                    end
                end else if (mdu_start_i) begin
                    pc_stall_o               = 1'b1;
                    stall_o[ID_EX:IF_ID]     = 2'b11;
                    hold_o[EX_MEM]           = 1'b1;
                    state_d                  = S_MDU_WAIT;
                end else if (br_taken_i) begin
                    redirect_o               = 1'b1;
                    hold_o[ID_EX:IF_ID]      = 2'b11;
                end else if (load_use_i) begin
                    pc_stall_o               = 1'b1;
                    stall_o[IF_ID]           = 1'b1;
                    hold_o[ID_EX]            = 1'b1;
                end
            end
            S_MDU_WAIT: begin
                if (mdu_done_i) begin
                    state_d = S_RUN;
                end else begin
                    pc_stall_o           = 1'b1;
                    stall_o[ID_EX:IF_ID] = 2'b11;
                    hold_o[EX_MEM]       = 1'b1;
                end
            end
            S_TRAP_DRAIN: begin
                flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase

        if (flush) begin
            hold_o[EX_MEM:IF_ID] = 3'b111;
        end

        // Bus wait freezes the front of the pipe and bubbles WB; only the
        // trap flush bubbles survive it.
        if (bus_wait) begin
            pc_stall_o           = 1'b1;
            stall_o              = 4'b0111;
            hold_o               = 4'b1000;
            hold_o[EX_MEM:IF_ID] = flush ? 3'b111 : 3'b000;
        end
    end

    sat_counter #(
        .WIDTH(PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_stall_o),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use, br_taken, mdu_start, mdu_done, mem_req, mem_ack, trap;

    logic        pc_stall, redirect, trap_ack, busy;
    logic [3:0]  stall, hold;
    logic [31:0] stall_cnt;
    state_t      state;

    logic        s_pc_stall, s_redirect, s_trap_ack, s_busy;
    logic [3:0]  s_stall, s_hold;
    logic [2:0]  s_stall_cnt;
    state_t      s_state;

    int checks = 0;
    int errors = 0;

    // model: pending MDU op, remaining flush cycles after this one, perf counts
    bit     m_mdu;
    int     m_drain;
    longint m_cnt;
    int     m_cnt_sat;

    always #5 clk = ~clk;

    pipe_ctrl #(.TRAP_DRAIN(TD), .CNT_W(2), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_use_i(load_use), .br_taken_i(br_taken),
        .mdu_start_i(mdu_start), .mdu_done_i(mdu_done), .mem_req_i(mem_req),
        .mem_ack_i(mem_ack), .trap_i(trap), .pc_stall_o(pc_stall), .stall_o(stall),
        .hold_o(hold), .redirect_o(redirect), .trap_ack_o(trap_ack), .busy_o(busy),
        .stall_cnt_o(stall_cnt), .state_o(state)
    );

    pipe_ctrl #(.TRAP_DRAIN(TD), .CNT_W(2), .PERF_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .load_use_i(load_use), .br_taken_i(br_taken),
        .mdu_start_i(mdu_start), .mdu_done_i(mdu_done), .mem_req_i(mem_req),
        .mem_ack_i(mem_ack), .trap_i(trap), .pc_stall_o(s_pc_stall), .stall_o(s_stall),
        .hold_o(s_hold), .redirect_o(s_redirect), .trap_ack_o(s_trap_ack), .busy_o(s_busy),
        .stall_cnt_o(s_stall_cnt), .state_o(s_state)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_out(output logic e_pc, output logic [3:0] e_stall,
                                      output logic [3:0] e_hold, output logic e_red,
                                      output logic e_ack, output logic [1:0] e_state,
                                      output logic e_accept);
        logic bw;
        logic flushing;
        bw = mem_req & ~mem_ack;
        e_pc = 0; e_stall = 0; e_hold = 0; e_red = 0; e_ack = 0; e_accept = 0;
        flushing = 0;
        if (m_drain > 0) begin
            e_state = 2'd2;
            flushing = 1;
        end else if (m_mdu) begin
            e_state = 2'd1;
            if (!mdu_done) begin
                e_pc = 1; e_stall = 4'b0011; e_hold = 4'b0100;
            end
        end else begin
            e_state = 2'd0;
            if (trap) begin
                if (!bw) begin
                    e_accept = 1; e_ack = 1; e_red = 1; flushing = 1;
                end
            end else if (mdu_start) begin
                e_pc = 1; e_stall = 4'b0011; e_hold = 4'b0100;
            end else if (br_taken) begin
                e_red = 1; e_hold = 4'b0011;
            end else if (load_use) begin
                e_pc = 1; e_stall = 4'b0001; e_hold = 4'b0010;
            end
        end
        if (flushing) e_hold = 4'b0111;
        if (bw) begin
            e_pc = 1;
            e_stall = 4'b0111;
            e_hold = flushing ? 4'b1111 : 4'b1000;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic e_pc, e_red, e_ack, e_acc;
        logic [3:0] e_stall, e_hold;
        logic [1:0] e_state;
        if (!rst_n) begin
            m_mdu = 0; m_drain = 0; m_cnt = 0; m_cnt_sat = 0;
        end else begin
            model_out(e_pc, e_stall, e_hold, e_red, e_ack, e_state, e_acc);
            if (e_pc) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt_sat < 7) m_cnt_sat++;
            end
            if (m_drain > 0) m_drain--;
            else if (m_mdu) begin
                if (mdu_done) m_mdu = 0;
            end else if (trap) begin
                if (e_acc) m_drain = TD - 1;
            end else if (mdu_start) m_mdu = 1;
        end
    end

    always @(negedge clk) begin
        logic e_pc, e_red, e_ack, e_acc;
        logic [3:0] e_stall, e_hold;
        logic [1:0] e_state;
        model_out(e_pc, e_stall, e_hold, e_red, e_ack, e_state, e_acc);
        chk("pc_stall", 64'(pc_stall), 64'(e_pc));
        chk("stall", 64'(stall), 64'(e_stall));
        chk("hold", 64'(hold), 64'(e_hold));
        chk("redirect", 64'(redirect), 64'(e_red));
        chk("trap_ack", 64'(trap_ack), 64'(e_ack));
        chk("busy", 64'(busy), 64'(e_state != 2'd0));
        chk("state", 64'(state), 64'(e_state));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("stall_cnt_sat", 64'(s_stall_cnt), 64'(m_cnt_sat));
    end

    task automatic drive(input logic lu, input logic br, input logic ms, input logic md,
                         input logic mr, input logic ma, input logic tr);
        load_use = lu; br_taken = br; mdu_start = ms; mdu_done = md;
        mem_req = mr; mem_ack = ma; trap = tr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, acks, flushes, ack_at[$];
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset and idle
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("idle_stall", 64'({pc_stall, stall, hold}), 64'd0);
        chk("idle_misc", 64'({redirect, trap_ack, busy}), 64'd0);
        chk("idle_cnt", 64'(stall_cnt), 64'd0);
        tick();

        // load-use pulse
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("lu_pc", 64'(pc_stall), 64'd1);
        chk("lu_stall", 64'(stall), 64'b0001);
        chk("lu_hold", 64'(hold), 64'b0010);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_after", 64'({pc_stall, stall, hold}), 64'd0);
        chk("lu_cnt", 64'(stall_cnt), 64'd1);
        tick();

        // MDU op, done five cycles after start
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, i == 0, i == 5, 0, 0, 0);
            if (i < 5 && pc_stall && stall == 4'b0011 && hold == 4'b0100) n++;
            if (i == 5) chk("mdu_done_out", 64'({pc_stall, stall, hold}), 64'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mdu_stall_cycles", 64'(n), 64'd5);
        chk("mdu_cnt", 64'(stall_cnt), 64'd6);
        chk("mdu_busy_after", 64'(busy), 64'd0);

        // trap with branch and load-use, held for the flush length
        acks = 0; flushes = 0;
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, i < 3, 0, 0, 0, 0, i < 3);
            if (trap_ack) acks++;
            if (hold == 4'b0111) flushes++;
            tick();
        end
        chk("trap_acks", 64'(acks), 64'd1);
        chk("trap_flush_cycles", 64'(flushes), 64'd3);

        // trap held one cycle longer: re-acked only once back in RUN
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 0, 0, i < 4);
            if (trap_ack) ack_at.push_back(i);
            tick();
        end
        chk("retrap_acks", 64'(ack_at.size()), 64'd2);
        if (ack_at.size() == 2) chk("retrap_pos", 64'(ack_at[1]), 64'd3);

        // bus wait while trap pending
        n = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, i == 4, 1);
            if (i < 4 && stall == 4'b0111 && hold == 4'b1000 && !trap_ack) n++;
            if (i == 4) chk("bus_trap_ack", 64'(trap_ack), 64'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("bus_wait_cycles", 64'(n), 64'd4);
        chk("bus_cnt", 64'(stall_cnt), 64'd10);
        chk("sat_cnt", 64'(s_stall_cnt), 64'd7);
        repeat (3) tick();

        // reset during MDU_WAIT
        drive(0, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mdu_out", 64'({busy, pc_stall, stall, hold}), 64'd0);
        chk("rst_mdu_cnt", 64'(stall_cnt), 64'd0);
        tick();
        rst_n = 1'b1;

        // reset during TRAP_DRAIN
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_drain", 64'(hold), 64'b0111);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_drain_out", 64'({busy, hold, trap_ack, redirect}), 64'd0);
        chk("rst_drain_cnt", 64'(s_stall_cnt), 64'd0);
        tick();
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 8);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
